// File: rtl/keypad_token_fifo.sv
// Keypad front end: ASCII keys build a signed operand, operator keys
// push {operand, operator} tokens into a first-word-fall-through FIFO.
module keypad_token_fifo #(
  parameter int DATA_W  = 32,
  parameter int NDIGITS = 8,
  parameter int DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     key_code,
  input  logic                           key_valid,
  output logic [DATA_W-1:0]              tok_data,
  output logic [4:0]                     tok_op,
  output logic                           tok_has_num,
  output logic                           tok_ovf,
  output logic                           tok_valid,
  input  logic                           tok_ready,
  output logic                           overflow,
  output logic [$clog2(NDIGITS+1)-1:0]   ndigits,
  output logic                           key_drop,
  output logic                           key_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(NDIGITS+1);
  localparam int XW = DATA_W + 4;
  localparam logic [XW-1:0] MAX_POS =
    {5'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_OVF
  } state_e;

  typedef struct packed {
    logic              ovf;
    logic              has_num;
    logic [4:0]        op;
    logic [DATA_W-1:0] data;
  } tok_t;

  state_e            state_q;
  logic [DATA_W-1:0] mag_q;
  logic              sign_q;
  logic [NW-1:0]     nd_q;
  logic              ovf_q;
  logic              drop_q;
  logic              err_q;
  logic [AW:0]       wr_q;
  logic [AW:0]       rd_q;
  tok_t              mem_q [DEPTH];

  logic              is_dig;
  logic              is_op;
  logic              is_neg;
  logic              is_clr;
  logic [4:0]        op_hot;
  logic [3:0]        dig;
  logic [XW-1:0]     mag_x;
  logic [XW-1:0]     mag_nx;
  logic              dig_ovf;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              clr;
  tok_t              push_tok;
  tok_t              head;

  // Classify the incoming key into one of the key groups
  always_comb begin
    is_dig = 1'b0;
    is_op  = 1'b0;
    is_neg = 1'b0;
    is_clr = 1'b0;
    op_hot = 5'b00000;
    case (key_code)
      8'h2B: begin is_op = 1'b1; op_hot = 5'b00001; end
      8'h2D: begin is_op = 1'b1; op_hot = 5'b00010; end
      8'h2A: begin is_op = 1'b1; op_hot = 5'b00100; end
      8'h2F: begin is_op = 1'b1; op_hot = 5'b01000; end
      8'h3D: begin is_op = 1'b1; op_hot = 5'b10000; end
      8'h6E: is_neg = 1'b1;
      8'h43: is_clr = 1'b1;
      default: is_dig = (key_code >= 8'h30) &&
                        (key_code <= 8'h39);
    endcase
  end

  // Next magnitude in widened arithmetic so the range test cannot wrap
  always_comb begin
    dig     = key_code[3:0];
    mag_x   = {4'b0, mag_q};
    mag_nx  = (mag_x << 3) + (mag_x << 1) + XW'(dig);
    dig_ovf = (nd_q == NW'(NDIGITS)) || (mag_nx > MAX_POS);
  end

  // FIFO status, handshake and the token an operator key would push
  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[AW] != rd_q[AW]) &&
            (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop   = !empty && tok_ready;
    clr   = key_valid && is_clr;
    push  = key_valid && is_op && (!full || pop);
    push_tok.data    = sign_q ? -mag_q : mag_q;
    push_tok.op      = op_hot;
    push_tok.has_num = (state_q != S_IDLE);
    push_tok.ovf     = ovf_q;
  end

  // Operand entry FSM with registered status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      nd_q    <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      err_q  <= 1'b0;
      if (key_valid) begin
        unique case (1'b1)
          is_clr: begin
            state_q <= S_IDLE;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            nd_q    <= '0;
            ovf_q   <= 1'b0;
          end
          is_neg: sign_q <= ~sign_q;
          is_dig: begin
            if (state_q != S_OVF) begin
              if (dig_ovf) begin
                ovf_q   <= 1'b1;
                state_q <= S_OVF;
              end else begin
                mag_q   <= mag_nx[DATA_W-1:0];
                nd_q    <= nd_q + NW'(1);
                state_q <= S_ENTRY;
              end
            end
          end
          is_op: begin
            if (push) begin
              state_q <= S_IDLE;
              mag_q   <= '0;
              sign_q  <= 1'b0;
              nd_q    <= '0;
              ovf_q   <= 1'b0;
            end else begin
              drop_q <= 1'b1;
            end
          end
          default: err_q <= 1'b1;
        endcase
      end
    end
  end

  // FIFO pointers; clear wins over a simultaneous pop
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Token storage; a push into a full FIFO reuses the slot being popped
  always_ff @(posedge clk) begin
    if (!rst && !clr && push)
      mem_q[wr_q[AW-1:0]] <= push_tok;
  end

  assign head        = mem_q[rd_q[AW-1:0]];
  assign tok_valid   = !empty;
  assign tok_data    = tok_valid ? head.data : '0;
  assign tok_op      = tok_valid ? head.op : '0;
  assign tok_has_num = tok_valid && head.has_num;
  assign tok_ovf     = tok_valid && head.ovf;
  assign overflow    = ovf_q;
  assign ndigits     = nd_q;
  assign key_drop    = drop_q;
  assign key_err     = err_q;

endmodule

// File: tb/tb_keypad_token_fifo.sv
// Bench for keypad_token_fifo: two widths share one key stream,
// each checked every cycle against a queue-based model.
module tb_keypad_token_fifo;

  localparam int DEPTH = 4;
  localparam int NDIG  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  key_code = 8'h00;
  logic        key_valid = 1'b0;
  logic        tok_ready = 1'b0;

  logic [31:0] d0;
  logic [7:0]  d1;
  logic [4:0]  op0, op1;
  logic        has0, has1, tov0, tov1, v0, v1;
  logic        ovl0, ovl1, dr0, dr1, er0, er1;
  logic [3:0]  nd0, nd1;

  keypad_token_fifo #(.DATA_W(32), .NDIGITS(NDIG), .DEPTH(DEPTH)) u0 (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .tok_data(d0), .tok_op(op0), .tok_has_num(has0), .tok_ovf(tov0),
    .tok_valid(v0), .tok_ready(tok_ready), .overflow(ovl0),
    .ndigits(nd0), .key_drop(dr0), .key_err(er0)
  );

  keypad_token_fifo #(.DATA_W(8), .NDIGITS(NDIG), .DEPTH(DEPTH)) u1 (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .tok_data(d1), .tok_op(op1), .tok_has_num(has1), .tok_ovf(tov1),
    .tok_valid(v1), .tok_ready(tok_ready), .overflow(ovl1),
    .ndigits(nd1), .key_drop(dr1), .key_err(er1)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    int     op;
    bit     has;
    bit     ovf;
  } tok_t;

  tok_t   q0[$];
  tok_t   q1[$];
  longint m_mag [2];
  bit     m_sign[2];
  int     m_nd  [2];
  bit     m_ovf [2];
  bit     e_drop[2];
  bit     e_err [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int op_of(input logic [7:0] k);
    case (k)
      8'h2B:   return 1;
      8'h2D:   return 2;
      8'h2A:   return 4;
      8'h2F:   return 8;
      8'h3D:   return 16;
      default: return 0;
    endcase
  endfunction

  task automatic mclear(input int i);
    m_mag[i]  = 0;
    m_sign[i] = 0;
    m_nd[i]   = 0;
    m_ovf[i]  = 0;
  endtask

  task automatic mstep(input int i, input int W);
    longint maxv;
    int     sz;
    bit     pop;
    bit     push;
    longint nxt;
    tok_t   t;
    maxv = (longint'(1) << (W-1)) - 1;
    sz   = (i == 0) ? q0.size() : q1.size();
    e_drop[i] = 0;
    e_err[i]  = 0;
    push = 0;
    t    = '{0, 0, 0, 0};
    if (rst) begin
      mclear(i);
      if (i == 0) q0.delete(); else q1.delete();
      return;
    end
    pop = (sz > 0) && tok_ready;
    if (key_valid) begin
      if (key_code == 8'h43) begin
        mclear(i);
        if (i == 0) q0.delete(); else q1.delete();
        pop = 0;
      end else if (key_code == 8'h6E) begin
        m_sign[i] = !m_sign[i];
      end else if (key_code >= 8'h30 && key_code <= 8'h39) begin
        if (!m_ovf[i]) begin
          nxt = m_mag[i] * 10 + longint'(key_code - 8'h30);
          if (m_nd[i] == NDIG || nxt > maxv) begin
            m_ovf[i] = 1;
          end else begin
            m_mag[i] = nxt;
            m_nd[i]++;
          end
        end
      end else if (op_of(key_code) != 0) begin
        if (sz < DEPTH || pop) begin
          push  = 1;
          t.data = m_sign[i] ? -m_mag[i] : m_mag[i];
          t.op   = op_of(key_code);
          t.has  = (m_nd[i] > 0) || m_ovf[i];
          t.ovf  = m_ovf[i];
          mclear(i);
        end else begin
          e_drop[i] = 1;
        end
      end else begin
        e_err[i] = 1;
      end
    end
    if (pop) begin
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (push) begin
      if (i == 0) q0.push_back(t); else q1.push_back(t);
    end
  endtask

  task automatic cmpi(input int i, input int W, input logic v,
                      input logic [63:0] data, input logic [4:0] op,
                      input logic has, input logic ovf,
                      input logic ovl, input logic [3:0] nd,
                      input logic dr, input logic er);
    tok_t   h;
    bit     ev;
    longint mask;
    string  p;
    p    = $sformatf("u%0d_", i);
    ev   = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
    h    = '{0, 0, 0, 0};
    if (ev) h = (i == 0) ? q0[0] : q1[0];
    mask = (longint'(1) << W) - 1;
    chk({p, "tok_valid"}, 64'(v), 64'(ev));
    chk({p, "tok_data"}, data, 64'(h.data & mask));
    chk({p, "tok_op"}, 64'(op), 64'(h.op));
    chk({p, "tok_has_num"}, 64'(has), 64'(h.has));
    chk({p, "tok_ovf"}, 64'(ovf), 64'(h.ovf));
    chk({p, "overflow"}, 64'(ovl), 64'(m_ovf[i]));
    chk({p, "ndigits"}, 64'(nd), 64'(m_nd[i]));
    chk({p, "key_drop"}, 64'(dr), 64'(e_drop[i]));
    chk({p, "key_err"}, 64'(er), 64'(e_err[i]));
  endtask

  always @(posedge clk) begin
    mstep(0, 32);
    mstep(1, 8);
    #2;
    cmpi(0, 32, v0, 64'(d0), op0, has0, tov0, ovl0, nd0, dr0, er0);
    cmpi(1, 8, v1, 64'(d1), op1, has1, tov1, ovl1, nd1, dr1, er1);
  end

  task automatic key(input logic [7:0] k, input bit rdy = 1'b0);
    key_code  = k;
    key_valid = 1'b1;
    tok_ready = rdy;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    tok_ready = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic idle(input bit rdy = 1'b0);
    tok_ready = rdy;
    @(posedge clk);
    #1;
    tok_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 64'(v0), 0);
    chk("rst_nd", 64'(nd0), 0);

    key("1"); key("2"); key("3"); key("+");
    chk("t1_data", 64'(d0), 123);
    chk("t1_op", 64'(op0), 5'b00001);
    chk("t1_has", 64'(has0), 1);
    chk("t1_ovf", 64'(tov0), 0);
    chk("t1_nd", 64'(nd0), 0);
    idle(1);
    chk("t1_pop", 64'(v0), 0);

    key("n"); key("4"); key("5"); key("*"); key("=");
    chk("t2_data", 64'(d0), 64'h0000_0000_FFFF_FFD3);
    chk("t2_op", 64'(op0), 5'b00100);
    chk("t2_has", 64'(has0), 1);
    idle(1);
    chk("t2_op2", 64'(op0), 5'b10000);
    chk("t2_has2", 64'(has0), 0);
    chk("t2_data2", 64'(d0), 0);
    idle(1);
    chk("t2_empty", 64'(v0), 0);

    repeat (8) key("9");
    chk("t3_nd8", 64'(nd0), 8);
    chk("t3_noovf", 64'(ovl0), 0);
    key("9");
    chk("t3_ovf", 64'(ovl0), 1);
    chk("t3_ndhold", 64'(nd0), 8);
    key("/");
    chk("t3_data", 64'(d0), 99999999);
    chk("t3_tovf", 64'(tov0), 1);
    chk("t3_op", 64'(op0), 5'b01000);
    chk("t3_ovfclr", 64'(ovl0), 0);
    idle(1);

    key("1"); key("2"); key("8");
    chk("t4_ovf8", 64'(ovl1), 1);
    chk("t4_nd8", 64'(nd1), 2);
    chk("t4_ovf32", 64'(ovl0), 0);
    key("-");
    chk("t4_data8", 64'(d1), 12);
    chk("t4_tovf8", 64'(tov1), 1);
    chk("t4_op8", 64'(op1), 5'b00010);
    chk("t4_data32", 64'(d0), 128);
    idle(1);

    repeat (4) key("+");
    chk("t5_full", 64'(v0), 1);
    key("+");
    chk("t5_drop0", 64'(dr0), 1);
    chk("t5_drop1", 64'(dr1), 1);
    key("+", 1'b1);
    chk("t5_nodrop", 64'(dr0), 0);
    repeat (4) idle(1);
    chk("t5_drained", 64'(v0), 0);

    repeat (3) key("+");
    key("7"); key("7");
    chk("t6_nd", 64'(nd0), 2);
    key("C");
    chk("t6_clr_valid", 64'(v0), 0);
    chk("t6_clr_nd", 64'(nd0), 0);
    key(8'h78);
    chk("t6_err", 64'(er0), 1);
    idle();
    chk("t6_err_end", 64'(er0), 0);
    key("+"); key("5");
    chk("t6_pre_nd", 64'(nd0), 1);
    chk("t6_pre_valid", 64'(v0), 1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("t6_rst_valid", 64'(v0), 0);
    chk("t6_rst_nd", 64'(nd0), 0);
    chk("t6_rst_data", 64'(d0), 0);
    chk("t6_rst_ovf", 64'(ovl0), 0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
